// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Optional build macro: PS2_RX_PARITY_CHK_EN (see ps2_rx.sv).
package ps2_pkg;

  // Deframing states: wait for start, shift data, take parity, check stop
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_rx_state_t;

  localparam int   PS2_DATA_BITS = 8;
  localparam logic PS2_START_BIT = 1'b0;
  localparam logic PS2_STOP_BIT  = 1'b1;

  // Odd parity: data bits plus parity bit must contain an odd number of ones
  function automatic logic ps2_odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                             input logic                     par);
    return ^{data, par};
  endfunction

endpackage : ps2_pkg

// File: rtl/ps2_sync_edge.sv
// Input conditioning for the PS/2 pins: two-flop synchronizers on kbd_clk and
// ps2_data, plus a registered falling-edge detector on the synced clock.
// The data copy is delayed one extra flop so it lines up with the registered
// fall pulse. All flops idle high like the bus, except the pulse itself.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic kbd_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall
);

  logic clk_meta_q;
  logic clk_sync_q;
  logic clk_prev_q;
  logic data_meta_q;
  logic data_sync_q;
  logic data_q;
  logic fall_q;

  // Two-flop synchronizers for both pins, reset to the idle-high bus level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= kbd_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Previous synced clock and registered one-cycle fall pulse with aligned data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_q <= 1'b1;
      data_q     <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_prev_q <= clk_sync_q;
      data_q     <= data_sync_q;
      fall_q     <= clk_prev_q & ~clk_sync_q;
    end
  end

  assign data_s = data_q;
  assign fall   = fall_q;

endmodule : ps2_sync_edge

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver feeding the LC3 keyboard registers.
// rdy -> KBSR[15], scan_code -> KBDR[7:0], rd_ack = KBDR read strobe.
// Build option: define PS2_RX_PARITY_CHK_EN to reject frames with bad odd
// parity; otherwise the parity bit is consumed but ignored.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbd_clk,
  input  logic       ps2_data,
  input  logic       rd_ack,
  output logic [7:0] scan_code,
  output logic       rdy,
  output logic       overrun,
  output logic       frame_err
);

  localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          data_s;
  logic          fall;

  ps2_rx_state_t state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          rdy_q, rdy_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;

  logic          timeout_s;
  logic          stop_evt_s;
  logic          frame_good_s;

`ifdef PS2_RX_PARITY_CHK_EN
  logic          par_q, par_d;
`endif

  ps2_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .kbd_clk  (kbd_clk),
    .ps2_data (ps2_data),
    .data_s   (data_s),
    .fall     (fall)
  );

  // A frame is abandoned when the keyboard stops clocking mid-frame
  assign timeout_s  = (state_q != IDLE) && !fall && (to_cnt_q == TO_LAST);
  // The stop bit arrives: the frame is complete and gets judged this cycle
  assign stop_evt_s = fall && (state_q == STOP);

`ifdef PS2_RX_PARITY_CHK_EN
  assign frame_good_s = (data_s == PS2_STOP_BIT) && ps2_odd_parity_ok(shift_q, par_q);
`else
  assign frame_good_s = (data_s == PS2_STOP_BIT);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: every bit advances on a fall; timeout forces IDLE
  always_comb begin
    state_d = state_q;
    if (timeout_s) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (data_s == PS2_START_BIT) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            state_d = DATA;
          end
        end
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM outputs: shifting, timeout counting, delivery and handshake
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    scan_code_d = scan_code_q;
    rdy_d       = rdy_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
`ifdef PS2_RX_PARITY_CHK_EN
    par_d       = par_q;
`endif

    // Idle time only matters while a frame is in flight
    if ((state_q == IDLE) || fall || timeout_s) begin
      to_cnt_d = {TW{1'b0}};
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    // Bit capture; a timeout throws the partial byte away
    if (timeout_s) begin
      shift_d   = 8'h00;
      bit_cnt_d = 3'd0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: begin
`ifdef PS2_RX_PARITY_CHK_EN
          par_d = data_s;
`else
          bit_cnt_d = bit_cnt_q;
`endif
        end
        STOP: begin
          bit_cnt_d = bit_cnt_q;
        end
        default: begin
          bit_cnt_d = 3'd0;
        end
      endcase
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    // A read acknowledges the buffered code and any pending overrun
    if (rd_ack && rdy_q) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end else begin
      rdy_d     = rdy_q;
      overrun_d = overrun_q;
    end

    // Delivery: load only into an empty (or simultaneously read) buffer
    if (stop_evt_s && frame_good_s) begin
      if (!rdy_q || rd_ack) begin
        scan_code_d = shift_q;
        rdy_d       = 1'b1;
      end else begin
        overrun_d   = 1'b1;
      end
    end else begin
      scan_code_d = scan_code_q;
    end

    // Bad frames and timeouts produce a single-cycle error pulse
    if ((stop_evt_s && !frame_good_s) || timeout_s) begin
      frame_err_d = 1'b1;
    end else begin
      frame_err_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      to_cnt_q    <= {TW{1'b0}};
      scan_code_q <= 8'h00;
      rdy_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      scan_code_q <= scan_code_d;
      rdy_q       <= rdy_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef PS2_RX_PARITY_CHK_EN
  // Latched parity bit, only kept when parity checking is built in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign scan_code = scan_code_q;
  assign rdy       = rdy_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule : ps2_rx

// File: tb/tb_ps2_rx.sv
// Directed plus randomized bench for ps2_rx with a frame-level reference model.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int TO = 200;
`ifdef PS2_RX_PARITY_CHK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       kbd_clk;
  logic       ps2_data;
  logic       rd_ack;
  logic [7:0] scan_code;
  logic       rdy;
  logic       overrun;
  logic       frame_err;

  int         n_cmp;
  int         n_bad;
  int         err_seen;
  logic       lat [0:4];

  logic [7:0] exp_code;
  logic       exp_rdy;
  logic       exp_ovr;
  int         exp_err;

  ps2_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kbd_clk   (kbd_clk),
    .ps2_data  (ps2_data),
    .rd_ack    (rd_ack),
    .scan_code (scan_code),
    .rdy       (rdy),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count clock cycles with frame_err high; each error must be exactly one
  always @(posedge clk) begin
    if (frame_err === 1'b1) err_seen <= err_seen + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_code"}, 32'(scan_code), 32'(exp_code));
    chk({tag, "_rdy"},  32'(rdy),       32'(exp_rdy));
    chk({tag, "_ovr"},  32'(overrun),   32'(exp_ovr));
    chk({tag, "_err"},  32'(err_seen),  32'(exp_err));
  endtask

  // Drive n bits (bit 0 first) on the pins; optionally strobe rd_ack on the
  // delivery edge of the last bit. lat[] records rdy after each low-phase edge.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit ack);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      ps2_data = bits[b];
      repeat (3) @(negedge clk);
      kbd_clk = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #1;
        lat[i] = rdy;
        @(negedge clk);
        rd_ack = (ack && (b == n - 1) && (i == 2));
      end
      kbd_clk = 1'b1;
    end
    repeat (3) @(negedge clk);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Send a full frame and apply the expected effect to the model
  task automatic frame(input logic [7:0] d, input bit bad_par, input bit stop_v, input bit ack);
    logic p;
    bit   good;
    p = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
    if (bad_par) p = ~p;
    send_bits({stop_v, p, d, 1'b0}, 11, ack);
    good = stop_v && (!PAR_CHK || !bad_par);
    if (ack) begin
      exp_rdy = 1'b0;
      exp_ovr = 1'b0;
    end
    if (!good) begin
      exp_err++;
    end else if (!exp_rdy) begin
      exp_code = d;
      exp_rdy  = 1'b1;
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    if (exp_rdy) begin
      exp_rdy = 1'b0;
      exp_ovr = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; err_seen = 0;
    exp_code = 8'h00; exp_rdy = 1'b0; exp_ovr = 1'b0; exp_err = 0;
    kbd_clk = 1'b1; ps2_data = 1'b1; rd_ack = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check_all("reset");
    chk("reset_state", 32'(dut.state_q), 32'(IDLE));

    // Good 8'h1C frame, delivery exactly four edges after the stop-bit fall
    frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("lat_edge3", 32'(lat[2]), 32'd0);
    chk("lat_edge4", 32'(lat[3]), 32'd1);
    check_all("good1c");
    pulse_ack();
    check_all("ack1c");

    // Back-to-back without a read: old code kept, overrun raised
    frame(8'h1C, 1'b0, 1'b1, 1'b0);
    frame(8'hF0, 1'b0, 1'b1, 1'b0);
    check_all("overrun");
    pulse_ack();
    check_all("ack_ovr");
    pulse_ack();
    check_all("ack_idle");

    // Parity bit forced to 1 on 8'h1C
    frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check_all("parity");
    pulse_ack();

    // Bad stop bit, then a good 8'h29
    frame(8'h29, 1'b0, 1'b0, 1'b0);
    check_all("stop_bad");
    chk("stop_bad_state", 32'(dut.state_q), 32'(IDLE));
    frame(8'h29, 1'b0, 1'b1, 1'b0);
    check_all("after_stop");
    pulse_ack();

    // Clock stalls after the 4th data bit: timeout, then a good 8'h5A
    send_bits(11'h7FE, 5, 1'b0);
    repeat (TO + 20) @(negedge clk);
    exp_err++;
    check_all("timeout");
    chk("timeout_state", 32'(dut.state_q), 32'(IDLE));
    frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check_all("after_to");

    // Delivery on the same edge as rd_ack while a code is still pending
    frame(8'h3B, 1'b0, 1'b1, 1'b1);
    check_all("ack_coinc");
    pulse_ack();

    // Randomized frames, faults and reads
    for (int k = 0; k < 12; k++) begin
      logic [7:0] d;
      bit bp, sv, ak;
      d  = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 3) != 0);
      ak = ($urandom_range(0, 2) == 0);
      frame(d, bp, sv, ak);
      check_all($sformatf("rnd%0d", k));
      if ($urandom_range(0, 2) == 0) pulse_ack();
    end

    // Reset mid-frame with a code pending: everything back to reset values at once
    frame(8'h77, 1'b0, 1'b1, 1'b0);
    send_bits(11'h7FE, 5, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_code",  32'(scan_code), 32'd0);
    chk("rst_rdy",   32'(rdy),       32'd0);
    chk("rst_ovr",   32'(overrun),   32'd0);
    chk("rst_ferr",  32'(frame_err), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    exp_code = 8'h00; exp_rdy = 1'b0; exp_ovr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    frame(8'hA5, 1'b0, 1'b1, 1'b0);
    check_all("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ps2_rx

// File: doc/ps2_rx.md
# ps2_rx

Receive side of the keyboard link: samples the `kbd_clk` / `ps2_data` pair coming from the keyboard model, deframes standard 11-bit PS/2 frames, and presents each received scan code to the LC3 keyboard device registers. Scan codes are held in a one-entry buffer with a ready/acknowledge handshake:

- `rdy` maps to KBSR[15].
- `scan_code` maps to KBDR[7:0].
- `rd_ack` is the KBDR read strobe.

Framing errors, timeouts and overruns are flagged, never silently merged into valid data.

## Interface
- `TIMEOUT_CYCLES`, default 20000: `clk` cycles without a `kbd_clk` falling edge before an in-progress frame is aborted.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `kbd_clk` in 1: PS/2 clock from the keyboard. Asynchronous to `clk`; idles high.
- `ps2_data` in 1: PS/2 data line. Asynchronous to `clk`; idles high.
- `rd_ack` in 1: one-cycle strobe. Consumes the buffered code.
- `scan_code` out 8: last accepted byte. Reset value 8'h00.
- `rdy` out 1: buffer holds an unread code. Reset value 0.
- `overrun` out 1: sticky flag; a valid frame was dropped because `rdy` was 1. Reset value 0.
- `frame_err` out 1: one-cycle pulse on a bad frame or a timeout. Reset value 0.

## Operation
- **Input conditioning.** `kbd_clk` and `ps2_data` each pass through a 2-flop synchronizer.
  - A registered copy of the synced clock gives `fall` = prev & ~cur, a one-cycle pulse.
  - Synchronizer flops reset to 1.
- **Frame format.** Each frame is, in order:
  - start bit (0);
  - 8 data bits, LSB first;
  - odd parity bit (XOR of the 8 data bits and the parity bit equals 1);
  - stop bit (1).
  - Every bit is sampled on `fall`.
- **State machine.** States are IDLE, DATA, PARITY, STOP.
  - IDLE:
    - `fall` with data=0 → DATA, and `bit_cnt` is cleared to 0.
    - `fall` with data=1 → stay in IDLE (line noise, no error).
  - DATA: on each `fall`, shift right with data entering bit 7, and increment `bit_cnt`. When `bit_cnt` reaches 7 on a `fall` → PARITY.
  - PARITY: on `fall`, latch the parity bit → STOP.
  - STOP: on `fall` → IDLE. The frame is good if stop=1 and parity passes (see Configuration).
    - Good frame and `rdy`=0: load `scan_code`, set `rdy`.
    - Good frame and `rdy`=1: keep the old `scan_code`, set `overrun`.
    - Bad frame: pulse `frame_err`; `scan_code` and `rdy` are unchanged.
- **Timeout.**
  - The counter clears on every `fall` and counts only outside IDLE.
  - When it reaches TIMEOUT_CYCLES-1: → IDLE, pulse `frame_err`, discard the partial byte.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- **Handshake.**
  - `rd_ack` clears `rdy` and `overrun` on the next edge.
  - `rd_ack` while `rdy`=0 has no effect.
  - `rd_ack` in the same cycle as a good-frame delivery: the new code loads, `rdy` stays 1, and no overrun is raised.
- **Reset.** Asserting `rst_n` low mid-frame immediately returns the block to IDLE and clears all outputs to their reset values. The partial frame is lost.

## Timing
- Latency:
  - pin fall → `fall` pulse: 3 `clk` edges (±1 from asynchronous sampling);
  - stop-bit `fall` → `rdy`/`scan_code` update: 1 edge;
  - total: 4 edges after the stop-bit pin fall.
- `frame_err` is high for exactly one cycle, on the edge after the offending `fall` or the timeout.
- The input must stay in a state at least 3 `clk` cycles per `kbd_clk` phase; otherwise the behaviour is undefined.
- Throughput: one byte per frame. The buffer is a single entry.

## Configuration
- `PS2_RX_PARITY_CHK_EN`:
  - Defined: the parity failure condition makes the frame bad (`frame_err` pulse, byte dropped).
  - Undefined: the parity bit is still consumed in the PARITY state but ignored. Only the stop bit and the timeout can flag an error.

## Structure
- `ps2_pkg` holds:
  - `typedef enum logic [1:0] ps2_rx_state_t` {IDLE, DATA, PARITY, STOP};
  - `PS2_DATA_BITS` = 8;
  - `PS2_START_BIT` = 1'b0, `PS2_STOP_BIT` = 1'b1.
- Sub-module `ps2_sync_edge`:
  - 2-flop synchronizers for both lines plus the falling-edge detector;
  - outputs: `data_s`, `fall`;
  - reset: asynchronous, active-low, flops reset high.

## Test plan
- Good frame for 8'h1C:
  - stimulus: start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1;
  - response: `rdy`=1 and `scan_code`=8'h1C four edges after the stop fall. `rd_ack` pulse → `rdy`=0.
- Back-to-back frames 8'h1C then 8'hF0 with no `rd_ack` → `scan_code` stays 8'h1C, `overrun`=1. Then `rd_ack` → `rdy`=0, `overrun`=0.
- Frame for 8'h1C with parity bit 1:
  - `PS2_RX_PARITY_CHK_EN` defined → one-cycle `frame_err`, `rdy` stays 0;
  - undefined → `rdy`=1, `scan_code`=8'h1C.
- Stop bit driven 0 → `frame_err` pulse, `rdy`=0, FSM in IDLE. A following good 8'h29 frame is received correctly.
- `kbd_clk` held high for TIMEOUT_CYCLES after the 4th data bit → `frame_err` pulse, FSM in IDLE. A following good 8'h5A frame is received.
- Frame delivery coinciding with `rd_ack` → new code loaded, `rdy`=1, `overrun`=0. `rst_n` low mid-frame → all outputs 0, FSM in IDLE immediately.
